dps_sci_arbiter: RTL and testbench

DPS_SCI_ARBITER -- requirements
Module: dps_sci_arbiter

---
 rtl/dps_sci_pkg.sv | 31 +++
 rtl/dps_sci_rr_arb2.sv | 18 +
 rtl/dps_sci_arbiter.sv | 149 ++++++++++++++
 tb/tb_dps_sci_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dps_sci_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dps_sci_pkg
//  Brief    : Shared constants and types for the SCI two-master arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package dps_sci_pkg;

   localparam logic [1:0] SCITX    = 2'd0;
   localparam logic [1:0] SCIRX    = 2'd1;
   localparam logic [1:0] SCICFG   = 2'd2;
   localparam logic [1:0] SCIUNMAP = 2'd3;

   localparam logic [0:0] ST_IDLE      = 1'b0;
   localparam logic [0:0] ST_READ_WAIT = 1'b1;

   localparam int P_TIMEOUT_DEF = 8;

   typedef struct packed {
      logic        rw;
      logic [1:0]  addr;
      logic [31:0] data;
   } sci_req_t;

   // Never narrower than one bit, even for a zero timeout.
   function automatic int cnt_width(input int t);
      return (t < 1) ? 1 : $clog2(t + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dps_sci_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : dps_sci_rr_arb2
//  Brief    : Two-way round-robin grant from eligibility and last-grant pointer.
//  Revision : 1.0 - initial release
// ============================================================================
module dps_sci_rr_arb2 (
   input  logic [1:0] elig_i,
   input  logic       ptr_i,
   output logic [1:0] gnt_o
);

   // On a tie the master that did not win last time is granted.
   assign gnt_o[0] = elig_i[0] & (~elig_i[1] | ptr_i);
   assign gnt_o[1] = elig_i[1] & (~elig_i[0] | ~ptr_i);

endmodule
`default_nettype wire

// File: rtl/dps_sci_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dps_sci_arbiter
//  Brief    : Arbitrates two masters onto one SCI slave port with read timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module dps_sci_arbiter
   import dps_sci_pkg::*;
#(
   parameter int P_TIMEOUT = P_TIMEOUT_DEF
) (
   input  logic        iIF_CLOCK,
   input  logic        inRESET,
   input  logic        iM0_REQ_VALID,
   output logic        oM0_REQ_BUSY,
   input  logic        iM0_REQ_RW,
   input  logic [1:0]  iM0_REQ_ADDR,
   input  logic [31:0] iM0_REQ_DATA,
   output logic        oM0_REQ_VALID,
   output logic [31:0] oM0_REQ_DATA,
   input  logic        iM1_REQ_VALID,
   output logic        oM1_REQ_BUSY,
   input  logic        iM1_REQ_RW,
   input  logic [1:0]  iM1_REQ_ADDR,
   input  logic [31:0] iM1_REQ_DATA,
   output logic        oM1_REQ_VALID,
   output logic [31:0] oM1_REQ_DATA,
   output logic        oS_REQ_VALID,
   output logic        oS_REQ_RW,
   output logic [1:0]  oS_REQ_ADDR,
   output logic [31:0] oS_REQ_DATA,
   input  logic        iS_REQ_BUSY,
   input  logic        iS_REQ_VALID,
   input  logic [31:0] iS_REQ_DATA,
   output logic        oTIMEOUT
);

   localparam int            CW    = cnt_width(P_TIMEOUT);
   localparam logic [CW-1:0] C_TMO = CW'(P_TIMEOUT);

   logic [0:0]    state_q, state_d;
   logic          ptr_q, ptr_d;
   logic          owner_q, owner_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          synth_vld_q, synth_vld_d;
   logic          synth_own_q, synth_own_d;

   sci_req_t   m0_req, m1_req, g_req;
   logic [1:0] elig, gnt;
   logic       idle, g_vld, g_sel, read_local;
   logic       wait_resp, wait_tmo;
   logic       resp_vld, resp_own;
   logic [31:0] resp_data;

   assign m0_req = '{rw: iM0_REQ_RW, addr: iM0_REQ_ADDR, data: iM0_REQ_DATA};
   assign m1_req = '{rw: iM1_REQ_RW, addr: iM1_REQ_ADDR, data: iM1_REQ_DATA};

   assign idle = (state_q == ST_IDLE);

   // A TX write is held back while the slave FIFO is full.
   assign elig[0] = idle & iM0_REQ_VALID &
                    ~(iM0_REQ_RW & (iM0_REQ_ADDR == SCITX) & iS_REQ_BUSY);
   assign elig[1] = idle & iM1_REQ_VALID &
                    ~(iM1_REQ_RW & (iM1_REQ_ADDR == SCITX) & iS_REQ_BUSY);

   dps_sci_rr_arb2 u_rr (
      .elig_i (elig),
      .ptr_i  (ptr_q),
      .gnt_o  (gnt)
   );

   assign g_vld = |gnt;
   assign g_sel = gnt[1];
   assign g_req = g_sel ? m1_req : m0_req;

   // Reads of TX and the unmapped slot are answered locally with zero.
   assign read_local = ~g_req.rw & ((g_req.addr == SCITX) | (g_req.addr == SCIUNMAP));

   assign oS_REQ_VALID = inRESET & g_vld & ~read_local;
   assign oS_REQ_RW    = g_vld ? g_req.rw   : 1'b0;
   assign oS_REQ_ADDR  = g_vld ? g_req.addr : 2'd0;
   assign oS_REQ_DATA  = g_vld ? g_req.data : 32'd0;

   assign oM0_REQ_BUSY = ~(inRESET & gnt[0]);
   assign oM1_REQ_BUSY = ~(inRESET & gnt[1]);

   assign wait_resp = ~idle & iS_REQ_VALID;
   assign wait_tmo  = ~idle & ~iS_REQ_VALID & (cnt_q == C_TMO);

   assign resp_vld  = wait_resp | wait_tmo | (idle & synth_vld_q);
   assign resp_own  = idle ? synth_own_q : owner_q;
   assign resp_data = wait_resp ? iS_REQ_DATA : 32'd0;

   assign oM0_REQ_VALID = inRESET & resp_vld & ~resp_own;
   assign oM1_REQ_VALID = inRESET & resp_vld &  resp_own;
   assign oM0_REQ_DATA  = oM0_REQ_VALID ? resp_data : 32'd0;
   assign oM1_REQ_DATA  = oM1_REQ_VALID ? resp_data : 32'd0;
   assign oTIMEOUT      = inRESET & wait_tmo;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      synth_vld_d = 1'b0;
      synth_own_d = synth_own_q;
      if (idle) begin
         if (g_vld) begin
            ptr_d = g_sel;
            if (!g_req.rw) begin
               if (read_local) begin
                  synth_vld_d = 1'b1;
                  synth_own_d = g_sel;
               end else begin
                  state_d = ST_READ_WAIT;
                  owner_d = g_sel;
                  cnt_d   = '0;
               end
            end
         end
      end else begin
         if (wait_resp || wait_tmo) begin
            state_d = ST_IDLE;
         end else if (cnt_q != C_TMO) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge iIF_CLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state_q     <= ST_IDLE;
         ptr_q       <= 1'b1;
         owner_q     <= 1'b0;
         cnt_q       <= '0;
         synth_vld_q <= 1'b0;
         synth_own_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         synth_vld_q <= synth_vld_d;
         synth_own_q <= synth_own_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dps_sci_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dps_sci_arbiter
//  Brief    : Directed self-checking bench for dps_sci_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dps_sci_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_v, m0_rw, m1_v, m1_rw;
   logic [1:0]  m0_a, m1_a;
   logic [31:0] m0_d, m1_d;
   logic        m0_busy, m1_busy, m0_rv, m1_rv;
   logic [31:0] m0_rd, m1_rd;
   logic        s_v, s_rw;
   logic [1:0]  s_a;
   logic [31:0] s_d;
   logic        s_busy, s_rv;
   logic [31:0] s_rd;
   logic        tmo;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dps_sci_arbiter #(.P_TIMEOUT(8)) dut (
      .iIF_CLOCK     (clk),
      .inRESET       (rst_n),
      .iM0_REQ_VALID (m0_v),
      .oM0_REQ_BUSY  (m0_busy),
      .iM0_REQ_RW    (m0_rw),
      .iM0_REQ_ADDR  (m0_a),
      .iM0_REQ_DATA  (m0_d),
      .oM0_REQ_VALID (m0_rv),
      .oM0_REQ_DATA  (m0_rd),
      .iM1_REQ_VALID (m1_v),
      .oM1_REQ_BUSY  (m1_busy),
      .iM1_REQ_RW    (m1_rw),
      .iM1_REQ_ADDR  (m1_a),
      .iM1_REQ_DATA  (m1_d),
      .oM1_REQ_VALID (m1_rv),
      .oM1_REQ_DATA  (m1_rd),
      .oS_REQ_VALID  (s_v),
      .oS_REQ_RW     (s_rw),
      .oS_REQ_ADDR   (s_a),
      .oS_REQ_DATA   (s_d),
      .iS_REQ_BUSY   (s_busy),
      .iS_REQ_VALID  (s_rv),
      .iS_REQ_DATA   (s_rd),
      .oTIMEOUT      (tmo)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic clr();
      m0_v = 0; m0_rw = 0; m0_a = 0; m0_d = 0;
      m1_v = 0; m1_rw = 0; m1_a = 0; m1_d = 0;
      s_busy = 0; s_rv = 0; s_rd = 0;
   endtask

   initial begin
      rst_n = 0;
      clr();
      // Requests during reset must not be accepted
      m0_v = 1; m0_rw = 1; m0_a = 2'd2;
      mid();
      chk("rst_busy0", {31'd0, m0_busy}, 1);
      chk("rst_busy1", {31'd0, m1_busy}, 1);
      chk("rst_svld",  {31'd0, s_v}, 0);
      chk("rst_m0v",   {31'd0, m0_rv}, 0);
      chk("rst_tmo",   {31'd0, tmo}, 0);
      tick();
      rst_n = 1;
      clr();

      // Simultaneous CFG writes: M0 first, M1 next cycle
      m0_v = 1; m0_rw = 1; m0_a = 2'd2; m0_d = 32'h0000_00A0;
      m1_v = 1; m1_rw = 1; m1_a = 2'd2; m1_d = 32'h0000_00B1;
      mid();
      chk("tie0_svld",  {31'd0, s_v}, 1);
      chk("tie0_sdata", s_d, 32'h0000_00A0);
      chk("tie0_saddr", {30'd0, s_a}, 2);
      chk("tie0_busy0", {31'd0, m0_busy}, 0);
      chk("tie0_busy1", {31'd0, m1_busy}, 1);
      tick();
      m0_v = 0;
      mid();
      chk("tie1_svld",  {31'd0, s_v}, 1);
      chk("tie1_sdata", s_d, 32'h0000_00B1);
      chk("tie1_busy1", {31'd0, m1_busy}, 0);
      tick();
      clr();

      // TX write blocked by full FIFO; M1 CFG read goes through
      s_busy = 1;
      m0_v = 1; m0_rw = 1; m0_a = 2'd0; m0_d = 32'h0000_0055;
      m1_v = 1; m1_rw = 0; m1_a = 2'd2;
      mid();
      chk("fifo_m1_svld", {31'd0, s_v}, 1);
      chk("fifo_m1_rw",   {31'd0, s_rw}, 0);
      chk("fifo_m1_busy", {31'd0, m1_busy}, 0);
      chk("fifo_m0_busy", {31'd0, m0_busy}, 1);
      tick();
      m1_v = 0;
      s_rv = 1; s_rd = 32'h0000_1234;
      mid();
      chk("fifo_m1_rv",   {31'd0, m1_rv}, 1);
      chk("fifo_m1_rd",   m1_rd, 32'h0000_1234);
      chk("fifo_m0_rv",   {31'd0, m0_rv}, 0);
      tick();
      s_rv = 0; s_rd = 0;
      for (int i = 2; i < 5; i++) begin
         mid();
         chk("fifo_hold_busy", {31'd0, m0_busy}, 1);
         chk("fifo_hold_svld", {31'd0, s_v}, 0);
         tick();
      end
      s_busy = 0;
      mid();
      chk("fifo_m0_svld",  {31'd0, s_v}, 1);
      chk("fifo_m0_sdata", s_d, 32'h0000_0055);
      chk("fifo_m0_busy0", {31'd0, m0_busy}, 0);
      tick();
      clr();

      // M1 reads RX, slave answers next cycle
      m1_v = 1; m1_rw = 0; m1_a = 2'd1;
      mid();
      chk("rx_svld",  {31'd0, s_v}, 1);
      chk("rx_saddr", {30'd0, s_a}, 1);
      tick();
      m1_v = 0;
      s_rv = 1; s_rd = 32'h8000_0041;
      mid();
      chk("rx_m1_rv", {31'd0, m1_rv}, 1);
      chk("rx_m1_rd", m1_rd, 32'h8000_0041);
      chk("rx_m0_rv", {31'd0, m0_rv}, 0);
      chk("rx_m0_rd", m0_rd, 0);
      tick();
      clr();

      // M0 reads RX, slave silent: forced completion after 8 wait cycles
      m0_v = 1; m0_rw = 0; m0_a = 2'd1;
      mid();
      chk("to_grant", {31'd0, s_v}, 1);
      tick();
      m0_v = 0;
      m1_v = 1; m1_rw = 1; m1_a = 2'd2; m1_d = 32'h0000_0077;
      for (int i = 1; i <= 8; i++) begin
         mid();
         chk("to_wait_tmo", {31'd0, tmo}, 0);
         chk("to_wait_rv",  {31'd0, m0_rv}, 0);
         chk("to_wait_b1",  {31'd0, m1_busy}, 1);
         tick();
      end
      mid();
      chk("to_fire_tmo", {31'd0, tmo}, 1);
      chk("to_fire_rv",  {31'd0, m0_rv}, 1);
      chk("to_fire_rd",  m0_rd, 0);
      chk("to_fire_b1",  {31'd0, m1_busy}, 1);
      tick();
      // Pointer now at M0, so M1 wins this tie
      m0_v = 1; m0_rw = 1; m0_a = 2'd2; m0_d = 32'h0000_0066;
      mid();
      chk("to_after_tmo",  {31'd0, tmo}, 0);
      chk("to_after_b1",   {31'd0, m1_busy}, 0);
      chk("to_after_b0",   {31'd0, m0_busy}, 1);
      chk("to_after_sdat", s_d, 32'h0000_0077);
      tick();
      clr();

      // Response on the timeout cycle wins and suppresses the pulse
      m0_v = 1; m0_rw = 0; m0_a = 2'd2;
      tick();
      m0_v = 0;
      for (int i = 1; i <= 8; i++) tick();
      s_rv = 1; s_rd = 32'hCAFE_F00D;
      mid();
      chk("race_rv",  {31'd0, m0_rv}, 1);
      chk("race_rd",  m0_rd, 32'hCAFE_F00D);
      chk("race_tmo", {31'd0, tmo}, 0);
      tick();
      clr();

      // Unmapped read answered locally; stray slave response ignored
      m0_v = 1; m0_rw = 0; m0_a = 2'd3;
      mid();
      chk("um_svld",  {31'd0, s_v}, 0);
      chk("um_busy0", {31'd0, m0_busy}, 0);
      tick();
      m0_v = 0;
      s_rv = 1; s_rd = 32'hDEAD_BEEF;
      mid();
      chk("um_rv",    {31'd0, m0_rv}, 1);
      chk("um_rd",    m0_rd, 0);
      chk("um_m1rv",  {31'd0, m1_rv}, 0);
      tick();
      mid();
      chk("stray_m0rv", {31'd0, m0_rv}, 0);
      chk("stray_m1rv", {31'd0, m1_rv}, 0);
      tick();
      clr();

      // Reset during a pending read abandons it
      m1_v = 1; m1_rw = 0; m1_a = 2'd1;
      tick();
      clr();
      rst_n = 0;
      mid();
      chk("rw_rst_busy0", {31'd0, m0_busy}, 1);
      chk("rw_rst_m1rv",  {31'd0, m1_rv}, 0);
      chk("rw_rst_tmo",   {31'd0, tmo}, 0);
      tick();
      rst_n = 1;
      s_rv = 1; s_rd = 32'h1111_2222;
      mid();
      chk("rw_late_m0rv", {31'd0, m0_rv}, 0);
      chk("rw_late_m1rv", {31'd0, m1_rv}, 0);
      tick();
      clr();
      m0_v = 1; m0_rw = 1; m0_a = 2'd2; m0_d = 32'h0000_00C0;
      m1_v = 1; m1_rw = 1; m1_a = 2'd2; m1_d = 32'h0000_00C1;
      mid();
      chk("rw_tie_sdata", s_d, 32'h0000_00C0);
      chk("rw_tie_busy0", {31'd0, m0_busy}, 0);
      chk("rw_tie_busy1", {31'd0, m1_busy}, 1);
      tick();
      clr();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
